// File: rtl/firebird_alu_sched_if.sv
// rtl/firebird_alu_sched_if.sv - request/response/ALU bundle between two requesters, the scheduler and a shared ALU
interface firebird_alu_sched_if #(
  parameter int XLEN = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [3:0]      req0_inst;
  logic [1:0]      req0_aluop;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [3:0]      req1_inst;
  logic [1:0]      req1_aluop;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_inst;
  logic [1:0]      alu_op;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            busy;

  modport master (
    output req_valid, req0_a, req0_b, req0_inst, req0_aluop,
           req1_a, req1_b, req1_inst, req1_aluop, rsp_ready,
           alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_zero,
           alu_a, alu_b, alu_inst, alu_op, busy
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_inst, req0_aluop,
           req1_a, req1_b, req1_inst, req1_aluop, rsp_ready,
           alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_zero,
           alu_a, alu_b, alu_inst, alu_op, busy
  );
endinterface

// File: rtl/firebird_alu_sched.sv
// rtl/firebird_alu_sched.sv - two-requester scheduler for one shared ALU (IDLE/EXEC/RESP)
// Define FIREBIRD_ALU_SCHED_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module firebird_alu_sched #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  firebird_alu_sched_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_grant;
  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  logic [3:0]      r_alu_inst;
  logic [1:0]      r_alu_op;
  logic [XLEN-1:0] r_rsp_result;
  logic            r_rsp_zero;
  logic [1:0]      r_rsp_valid;

  logic            w_win;
  logic [1:0]      w_win_oh;
  logic [1:0]      w_grant_oh;
  logic            w_accept;

`ifdef FIREBIRD_ALU_SCHED_RR_EN
  logic            r_last_grant;
  logic            r_rr_armed;

  // Until the first grant after reset there is no history, so a contest goes to requester 0.
  always_comb begin
    w_win = ~bus.req_valid[0];
    if (bus.req_valid == 2'b11) begin
      w_win = r_rr_armed ? ~r_last_grant : 1'b0;
    end
  end
`else
  assign w_win = ~bus.req_valid[0];
`endif

  assign w_win_oh   = w_win   ? 2'b10 : 2'b01;
  assign w_grant_oh = r_grant ? 2'b10 : 2'b01;
  assign w_accept   = rst_n && (r_state == IDLE) && (|bus.req_valid);

  assign bus.req_ready  = w_accept ? w_win_oh : 2'b00;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_inst   = r_alu_inst;
  assign bus.alu_op     = r_alu_op;
  assign bus.busy       = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_inst   <= 4'd0;
      r_alu_op     <= 2'd0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_valid  <= 2'b00;
`ifdef FIREBIRD_ALU_SCHED_RR_EN
      r_last_grant <= 1'b0;
      r_rr_armed   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_grant    <= w_win;
            r_alu_a    <= w_win ? bus.req1_a     : bus.req0_a;
            r_alu_b    <= w_win ? bus.req1_b     : bus.req0_b;
            r_alu_inst <= w_win ? bus.req1_inst  : bus.req0_inst;
            r_alu_op   <= w_win ? bus.req1_aluop : bus.req0_aluop;
`ifdef FIREBIRD_ALU_SCHED_RR_EN
            r_last_grant <= w_win;
            r_rr_armed   <= 1'b1;
`endif
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= bus.alu_result;
          r_rsp_zero   <= bus.alu_zero;
          r_rsp_valid  <= w_grant_oh;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[r_grant]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_firebird_alu_sched.sv
// tb/tb_firebird_alu_sched.sv - self-checking bench for firebird_alu_sched with an emulated shared ALU
module tb_firebird_alu_sched;
  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [XLEN-1:0] ra [2];
  logic [XLEN-1:0] rb [2];
  logic [3:0]      ri [2];
  logic [1:0]      ro [2];

  firebird_alu_sched_if #(.XLEN(XLEN)) ifc ();

  firebird_alu_sched #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_fn(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic [3:0] inst, input logic [1:0] op);
    logic [XLEN-1:0] r;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else begin
      case (inst[2:0])
        3'b000:  r = inst[3] ? a - b : a + b;
        3'b001:  r = a << b[4:0];
        3'b010:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        3'b011:  r = {{(XLEN-1){1'b0}}, (a < b)};
        3'b100:  r = a ^ b;
        3'b101:  r = inst[3] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'b110:  r = a | b;
        default: r = a & b;
      endcase
    end
    return r;
  endfunction

  assign ifc.req0_a     = ra[0];
  assign ifc.req0_b     = rb[0];
  assign ifc.req0_inst  = ri[0];
  assign ifc.req0_aluop = ro[0];
  assign ifc.req1_a     = ra[1];
  assign ifc.req1_b     = rb[1];
  assign ifc.req1_inst  = ri[1];
  assign ifc.req1_aluop = ro[1];
  assign ifc.alu_result = alu_fn(ifc.alu_a, ifc.alu_b, ifc.alu_inst, ifc.alu_op);
  assign ifc.alu_zero   = (ifc.alu_result == '0);

  task automatic drive(input int s, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [3:0] inst, input logic [1:0] op);
    ra[s] = a;
    rb[s] = b;
    ri[s] = inst;
    ro[s] = op;
  endtask

  task automatic drive_random(input int s);
    logic [XLEN-1:0] a;
    a = $urandom;
    drive(s, a, ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom),
          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.req_valid = 2'b11;
    ifc.rsp_ready = 2'b11;
    drive(0, 32'h1234, 32'h55, 4'hA, 2'b11);
    drive(1, 32'h9876, 32'h66, 4'h5, 2'b10);
    @(negedge clk); @(negedge clk); #1;
    total++; if (ifc.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", ifc.req_ready); end
    total++; if (ifc.rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", ifc.rsp_valid); end
    total++; if (ifc.rsp_result !== '0 || ifc.rsp_zero !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%h/%b exp=0/0", ifc.rsp_result, ifc.rsp_zero); end
    total++; if (ifc.alu_a !== '0 || ifc.alu_b !== '0) begin bad++; $display("FAIL reset_alu_ab got=%h/%h exp=0/0", ifc.alu_a, ifc.alu_b); end
    total++; if (ifc.alu_inst !== 4'd0 || ifc.alu_op !== 2'd0) begin bad++; $display("FAIL reset_alu_ctl got=%h/%b exp=0/00", ifc.alu_inst, ifc.alu_op); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    ifc.req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    ifc.rsp_ready = 2'b11;
    drive(0, 32'd5, 32'd3, 4'd0, 2'b00);
    ifc.req_valid = 2'b01;
    #1;
    total++; if (ifc.req_ready !== 2'b01) begin bad++; $display("FAIL add_req_ready got=%b exp=01", ifc.req_ready); end
    @(negedge clk); #1;
    total++; if (ifc.req_ready !== 2'b00 || ifc.busy !== 1'b1 || ifc.rsp_valid !== 2'b00) begin
      bad++; $display("FAIL add_exec got ready=%b busy=%b rsp_valid=%b exp 00/1/00", ifc.req_ready, ifc.busy, ifc.rsp_valid); end
    ifc.req_valid = 2'b00;
    @(negedge clk); #1;
    total++; if (ifc.rsp_valid !== 2'b01) begin bad++; $display("FAIL add_rsp_valid got=%b exp=01", ifc.rsp_valid); end
    total++; if (ifc.rsp_result !== 32'd8 || ifc.rsp_zero !== 1'b0) begin bad++; $display("FAIL add_result got=%0d/%b exp=8/0", ifc.rsp_result, ifc.rsp_zero); end
    @(negedge clk); #1;
    total++; if (ifc.rsp_valid !== 2'b00 || ifc.busy !== 1'b0) begin bad++; $display("FAIL add_done got=%b/%b exp=00/0", ifc.rsp_valid, ifc.busy); end
  endtask

  task automatic test_sub_zero();
    @(negedge clk);
    drive(1, 32'd7, 32'd7, 4'd0, 2'b01);
    ifc.req_valid = 2'b10;
    #1;
    total++; if (ifc.req_ready !== 2'b10) begin bad++; $display("FAIL sub_req_ready got=%b exp=10", ifc.req_ready); end
    @(negedge clk);
    ifc.req_valid = 2'b00;
    @(negedge clk); #1;
    total++; if (ifc.rsp_valid !== 2'b10) begin bad++; $display("FAIL sub_rsp_valid got=%b exp=10", ifc.rsp_valid); end
    total++; if (ifc.rsp_result !== '0 || ifc.rsp_zero !== 1'b1) begin bad++; $display("FAIL sub_result got=%0d/%b exp=0/1", ifc.rsp_result, ifc.rsp_zero); end
  endtask

  task automatic test_rtype_or();
    @(negedge clk);
    drive(0, 32'hF0, 32'h0F, 4'b0110, 2'b10);
    ifc.req_valid = 2'b01;
    @(negedge clk); #1;
    total++; if (ifc.alu_inst !== 4'b0110 || ifc.alu_op !== 2'b10) begin bad++; $display("FAIL or_alu_ctl got=%b/%b exp=0110/10", ifc.alu_inst, ifc.alu_op); end
    total++; if (ifc.alu_a !== 32'hF0 || ifc.alu_b !== 32'h0F) begin bad++; $display("FAIL or_alu_ab got=%h/%h exp=f0/0f", ifc.alu_a, ifc.alu_b); end
    ifc.req_valid = 2'b00;
    @(negedge clk); #1;
    total++; if (ifc.rsp_valid !== 2'b01 || ifc.rsp_result !== 32'hFF) begin bad++; $display("FAIL or_result got=%b/%h exp=01/ff", ifc.rsp_valid, ifc.rsp_result); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ifc.rsp_ready = 2'b00;
    drive(0, 32'd100, 32'd42, 4'd0, 2'b01);
    ifc.req_valid = 2'b01;
    @(negedge clk);
    ifc.req_valid = 2'b10;
    @(negedge clk); #1;
    total++; if (ifc.rsp_valid !== 2'b01 || ifc.rsp_result !== 32'd58) begin bad++; $display("FAIL bp_first got=%b/%0d exp=01/58", ifc.rsp_valid, ifc.rsp_result); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ifc.rsp_ready = (i % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      total++; if (ifc.rsp_valid !== 2'b01 || ifc.rsp_result !== 32'd58 || ifc.req_ready !== 2'b00) begin
        bad++; $display("FAIL bp_hold%0d got valid=%b result=%0d ready=%b exp 01/58/00", i, ifc.rsp_valid, ifc.rsp_result, ifc.req_ready); end
    end
    @(negedge clk);
    ifc.rsp_ready = 2'b01;
    ifc.req_valid = 2'b00;
    #1;
    total++; if (ifc.rsp_valid !== 2'b01) begin bad++; $display("FAIL bp_ack_cycle got=%b exp=01", ifc.rsp_valid); end
    @(negedge clk); #1;
    total++; if (ifc.rsp_valid !== 2'b00 || ifc.busy !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b exp=00/0", ifc.rsp_valid, ifc.busy); end
    ifc.rsp_ready = 2'b11;
  endtask

  task automatic test_reset_mid();
    logic [XLEN-1:0] exp;
    @(negedge clk);
    drive(0, 32'd9, 32'd4, 4'd0, 2'b01);
    ifc.req_valid = 2'b01;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (ifc.rsp_valid !== 2'b00 || ifc.busy !== 1'b0 || ifc.req_ready !== 2'b00) begin
      bad++; $display("FAIL mid_reset_ctl got valid=%b busy=%b ready=%b exp 00/0/00", ifc.rsp_valid, ifc.busy, ifc.req_ready); end
    total++; if (ifc.alu_a !== '0 || ifc.alu_op !== 2'b00 || ifc.rsp_result !== '0) begin
      bad++; $display("FAIL mid_reset_data got a=%h op=%b result=%h exp 0/00/0", ifc.alu_a, ifc.alu_op, ifc.rsp_result); end
    @(negedge clk);
    ifc.req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (ifc.rsp_valid !== 2'b00 || ifc.busy !== 1'b0) begin bad++; $display("FAIL mid_no_rsp got=%b/%b exp=00/0", ifc.rsp_valid, ifc.busy); end
    drive_random(0);
    exp = alu_fn(ra[0], rb[0], ri[0], ro[0]);
    ifc.req_valid = 2'b01;
    #1;
    total++; if (ifc.req_ready !== 2'b01) begin bad++; $display("FAIL mid_new_accept got=%b exp=01", ifc.req_ready); end
    @(negedge clk);
    ifc.req_valid = 2'b00;
    @(negedge clk); #1;
    total++; if (ifc.rsp_valid !== 2'b01 || ifc.rsp_result !== exp) begin bad++; $display("FAIL mid_new_result got=%b/%h exp=01/%h", ifc.rsp_valid, ifc.rsp_result, exp); end
  endtask

  task automatic test_contention();
    int g;
    int prev;
    logic [XLEN-1:0] exp;
    apply_reset();
    ifc.rsp_ready = 2'b11;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (prev != 1) drive_random(0);
      if (prev != 0) drive_random(1);
      ifc.req_valid = 2'b11;
`ifdef FIREBIRD_ALU_SCHED_RR_EN
      g = k % 2;
`else
      g = 0;
`endif
      exp = alu_fn(ra[g], rb[g], ri[g], ro[g]);
      #1;
      total++; if (ifc.req_ready !== 2'(1 << g)) begin bad++; $display("FAIL cont_grant%0d got=%b exp=%b", k, ifc.req_ready, 2'(1 << g)); end
      @(negedge clk);
      @(negedge clk); #1;
      total++; if (ifc.rsp_valid !== 2'(1 << g) || ifc.rsp_result !== exp) begin
        bad++; $display("FAIL cont_rsp%0d got=%b/%h exp=%b/%h", k, ifc.rsp_valid, ifc.rsp_result, 2'(1 << g), exp); end
      prev = g;
    end
    @(negedge clk);
    ifc.req_valid = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] pend;
    logic [1:0] v;
    logic [1:0] oh;
    logic [XLEN-1:0] exp;
    int g;
    int last;
    int stall;
    apply_reset();
    pend = 2'b00;
    last = -1;
    for (int t = 0; t < 40; t++) begin
      for (int n = $urandom_range(0, 2); n > 0; n--) begin
        @(negedge clk);
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'($urandom_range(0, 3));
        #1;
        total++; if (ifc.req_ready !== 2'b00 || ifc.busy !== 1'b0) begin bad++; $display("FAIL rnd_idle%0d got=%b/%b exp=00/0", t, ifc.req_ready, ifc.busy); end
      end
      @(negedge clk);
      v = pend | 2'($urandom_range(1, 3));
      for (int s = 0; s < 2; s++) if (!pend[s]) drive_random(s);
      ifc.req_valid = v;
      if (v == 2'b11) begin
`ifdef FIREBIRD_ALU_SCHED_RR_EN
        g = (last < 0) ? 0 : 1 - last;
`else
        g = 0;
`endif
      end else begin
        g = v[1] ? 1 : 0;
      end
      oh = 2'(1 << g);
      exp = alu_fn(ra[g], rb[g], ri[g], ro[g]);
      #1;
      total++; if (ifc.req_ready !== oh) begin bad++; $display("FAIL rnd_grant%0d got=%b exp=%b", t, ifc.req_ready, oh); end
      pend = v & ~oh;
      last = g;
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) pend = 2'b00;
      ifc.req_valid = pend;
      #1;
      total++; if (ifc.req_ready !== 2'b00) begin bad++; $display("FAIL rnd_exec%0d got=%b exp=00", t, ifc.req_ready); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        ifc.rsp_ready = (s == stall) ? (oh | 2'($urandom_range(0, 3))) : (~oh & 2'($urandom_range(0, 3)));
        #1;
        total++; if (ifc.rsp_valid !== oh || ifc.rsp_result !== exp || ifc.rsp_zero !== (exp == '0)) begin
          bad++; $display("FAIL rnd_rsp%0d got=%b/%h/%b exp=%b/%h/%b", t, ifc.rsp_valid, ifc.rsp_result, ifc.rsp_zero, oh, exp, (exp == '0)); end
      end
    end
    @(negedge clk);
    ifc.req_valid = 2'b00;
    #1;
    total++; if (ifc.busy !== 1'b0 || ifc.rsp_valid !== 2'b00) begin bad++; $display("FAIL rnd_end got=%b/%b exp=0/00", ifc.busy, ifc.rsp_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b1;
    ifc.req_valid = 2'b00;
    ifc.rsp_ready = 2'b11;
    for (int s = 0; s < 2; s++) drive(s, '0, '0, 4'd0, 2'd0);
    #2;
    test_reset();
    test_single_add();
    test_sub_zero();
    test_rtype_or();
    test_backpressure();
    test_reset_mid();
    test_contention();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/firebird_alu_sched.md
FIREBIRD_ALU_SCHED -- requirements
Module: firebird_alu_sched

Interface
REQ-001 Parameter XLEN, default 32, operand and result width.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester request accept.
REQ-006 req0_a, req0_b  input  XLEN each  requester 0 operands.
REQ-007 req0_inst  input  4  requester 0 {func30,func14,func13,func12}.
REQ-008 req0_aluop  input  2  requester 0 alu_op (00 add, 01 sub, 1x R-type).
REQ-009 req1_a, req1_b, req1_inst, req1_aluop  input  XLEN/XLEN/4/2  requester 1 equivalents.
REQ-010 rsp_valid  output  2  per-requester response valid.
REQ-011 rsp_ready  input  2  per-requester response accept.
REQ-012 rsp_result  output  XLEN  registered ALU result, shared by both requesters.
REQ-013 rsp_zero  output  1  registered ALU zero flag.
REQ-014 alu_a, alu_b  output  XLEN each  operands to the shared ALU.
REQ-015 alu_inst, alu_op  output  4/2  fields to the shared ALU control decoder.
REQ-016 alu_result, alu_zero  input  XLEN/1  combinational ALU outputs.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, EXEC and RESP, one-hot or binary.
REQ-019 IDLE: if any req_valid bit is set, the block SHALL assert req_ready combinationally for the single granted requester only, latch that requester's operands and fields into the ALU-input registers, record the grant index, and go to EXEC.
REQ-020 IDLE with req_valid=00: state SHALL be held, req_ready=00, and ALU-input registers SHALL be unchanged.
REQ-021 req_ready SHALL be 00 in EXEC and RESP.
REQ-022 alu_a/alu_b/alu_inst/alu_op SHALL be driven directly from the ALU-input registers in every state.
REQ-023 EXEC: the block SHALL capture alu_result into rsp_result and alu_zero into rsp_zero, then go to RESP.
REQ-024 RESP: the block SHALL assert rsp_valid only on the granted bit and hold rsp_result/rsp_zero stable until that requester's rsp_ready is sampled high.
REQ-025 RESP with rsp_ready high on the granted bit: the block SHALL return to IDLE, and rsp_valid SHALL fall on the next cycle.
REQ-026 rsp_ready on a non-granted bit SHALL be ignored.
REQ-027 Latency: with req accepted in cycle N, rsp_valid SHALL rise in cycle N+2; minimum issue interval is 3 cycles.
REQ-028 Simultaneous req_valid=11: arbitration per REQ-032/REQ-033; the losing request stays pending and is not dropped.
REQ-029 A requester SHALL be allowed to drop req_valid before grant without side effect.

Reset
REQ-030 While rst_n is low: state=IDLE, req_ready=00, rsp_valid=00, rsp_result=0, rsp_zero=0, alu_a=alu_b=0, alu_inst=0, alu_op=00, grant and last-grant registers=0, busy=0.
REQ-031 A reset asserted in EXEC or RESP SHALL abandon the transaction with no response delivered.

Configuration
REQ-032 With FIREBIRD_ALU_SCHED_RR_EN defined: round-robin; on req_valid=11 the requester not granted last SHALL win; last-grant updates at each accepted request; first contest after reset goes to requester 0.
REQ-033 Without FIREBIRD_ALU_SCHED_RR_EN: fixed priority; requester 0 SHALL always win on req_valid=11; no last-grant register is implemented.

Verification
REQ-034 Single add: req0 a=5 b=3 aluop=00, rsp_ready=11 -> req_ready=01 in cycle N, rsp_valid=01 in N+2, rsp_result=8, rsp_zero=0.
REQ-035 Subtract zero: req1 a=7 b=7 aluop=01 -> rsp_valid=10 in N+2, rsp_result=0, rsp_zero=1.
REQ-036 Contention, RR_EN defined: req_valid held 11 for 8 requests -> grants alternate 0,1,0,1,...; without the macro -> all grants go to 0 while req0 stays valid.
REQ-037 Backpressure: rsp_ready=00 for 5 cycles in RESP -> rsp_valid and rsp_result stable, req_ready=00; rsp_ready=01 -> IDLE next cycle.
REQ-038 Reset mid-op: rst_n pulled low in EXEC -> all outputs at reset values immediately; after release, a new req0 is accepted from IDLE.
REQ-039 R-type OR: req0 a=0xF0 b=0x0F inst=0110 aluop=10 -> alu_inst=0110 and alu_op=10 driven in EXEC; rsp_result=0xFF.
